// File: rtl/adder_seq_ctrl.sv
// Window sequencer for the 2x2-output accumulator: clears it, fetches the 16
// window pixels over a req/gnt read port and streams them in with their index.
module adder_seq_ctrl #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_W       = 12,
   parameter int P_START_ADDR = 11,
   parameter int P_MAX_OUTST  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_mode,
   input  logic [ADDR_W-1:0]     i_base_addr,
   output logic                  o_rd_req,
   output logic [ADDR_W-1:0]     o_rd_addr,
   input  logic                  i_rd_gnt,
   input  logic                  i_rd_valid,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic                  o_clear,
   output logic [DATA_WIDTH-1:0] o_pix_data,
   output logic [4:0]            o_coe_mode_addr,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err
);

   // state   | meaning
   // S_IDLE  | waiting for i_start
   // S_CLEAR | one-cycle accumulator clear
   // S_FETCH | issuing reads and forwarding responses
   // S_DONE  | one-cycle done pulse, sums are final
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FETCH, S_DONE} state_t;

   localparam logic [3:0] START_IDX = 4'(P_START_ADDR % 16);
   localparam logic [4:0] MAX_OUTST = 5'(P_MAX_OUTST);

   state_t            state, state_nxt;
   logic [4:0]        req_cnt, rsp_cnt, outst;
   logic              mode_q, err_q;
   logic [ADDR_W-1:0] base_q;
   logic [4:0]        coe_q;
   logic [3:0]        req_idx, rsp_idx;
   logic              start_acc, can_req, gnt_acc, rsp_acc, spurious;

   assign outst     = req_cnt - rsp_cnt;
   assign req_idx   = START_IDX + req_cnt[3:0];
   assign rsp_idx   = START_IDX + rsp_cnt[3:0];
   assign start_acc = (state == S_IDLE) && i_start;
   assign can_req   = (state == S_FETCH) && (req_cnt < 5'd16) && (outst < MAX_OUTST);
   assign gnt_acc   = can_req && i_rd_gnt;
   assign rsp_acc   = (state == S_FETCH) && i_rd_valid && (outst != 5'd0);
   // A response with nothing outstanding is a protocol error and is dropped.
   assign spurious  = (state != S_IDLE) && i_rd_valid && (outst == 5'd0);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_FETCH;
         S_FETCH: if (rsp_acc && (rsp_cnt == 5'd15)) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_clear         = (state == S_CLEAR);
      o_busy          = (state != S_IDLE);
      o_done          = (state == S_DONE);
      o_rd_req        = can_req;
      o_rd_addr       = '0;
      o_pix_data      = '0;
      o_coe_mode_addr = coe_q;
      o_err           = err_q;
      if (can_req) o_rd_addr = base_q + ADDR_W'(req_idx);
      if (rsp_acc) begin
         o_pix_data      = i_rd_data;
         o_coe_mode_addr = {mode_q, rsp_idx};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         req_cnt <= '0;
         rsp_cnt <= '0;
         mode_q  <= 1'b0;
         base_q  <= '0;
         coe_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (start_acc) begin
            mode_q  <= i_mode;
            base_q  <= i_base_addr;
            req_cnt <= '0;
            rsp_cnt <= '0;
            err_q   <= 1'b0;
         end
         if (gnt_acc) req_cnt <= req_cnt + 5'd1;
         // The accumulator holds while no pixel is presented, so keep the last address.
         if (rsp_acc) begin
            rsp_cnt <= rsp_cnt + 5'd1;
            coe_q   <= {mode_q, rsp_idx};
         end
         if (spurious) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: a pixel memory model with programmable
// response latency, per-scenario tasks checking against hand-derived values.
module tb_adder_seq_ctrl;

   logic        clk = 1'b0;
   logic        i_rst, i_start, i_mode, i_rd_gnt, i_rd_valid;
   logic [11:0] i_base_addr;
   logic [7:0]  i_rd_data;
   logic        o_rd_req, o_clear, o_busy, o_done, o_err;
   logic [11:0] o_rd_addr;
   logic [7:0]  o_pix_data;
   logic [4:0]  o_coe_mode_addr;

   always #5 clk = ~clk;

   adder_seq_ctrl #(.DATA_WIDTH(8), .ADDR_W(12), .P_START_ADDR(11), .P_MAX_OUTST(4)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
      .i_base_addr(i_base_addr), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
      .i_rd_gnt(i_rd_gnt), .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
      .o_clear(o_clear), .o_pix_data(o_pix_data), .o_coe_mode_addr(o_coe_mode_addr),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] grant_addr[$];
   logic [4:0]  beat_coe[$];
   logic [7:0]  beat_pix[$];
   int clear_cnt, clear_cyc, done_cnt, done_cyc, busy_first, busy_last, busy_cnt;
   int max_outst, grants_before_valid;
   bit req_at_full, x_seen, err_at_c1, err_at_done, err_after_spur, rst_zero, err_after_rst;
   logic [7:0] spur_pix;

   // Runs one window. Cycle 0 is the cycle i_start is presented; a second
   // start with different mode/base is offered at cycle 5 and must be ignored.
   task automatic run_window(input logic mode, input logic [11:0] base, input int lat,
                             input int gnt_mode, input bit data_const, input int spur_cyc,
                             input int rst_beat);
      int q_ready[$];
      int q_idx[$];
      int nreq = 0, nrsp = 0, first_valid = -1, rst_cyc = -1, cyc = 0, om;
      bit real_rsp, stop = 0;
      grant_addr.delete(); beat_coe.delete(); beat_pix.delete();
      clear_cnt = 0; clear_cyc = -1; done_cnt = 0; done_cyc = -1;
      busy_first = -1; busy_last = -1; busy_cnt = 0; max_outst = 0; grants_before_valid = 0;
      req_at_full = 0; x_seen = 0; err_at_c1 = 0; err_at_done = 0; err_after_spur = 0;
      rst_zero = 0; err_after_rst = 0; spur_pix = 8'hxx;
      while (!stop && cyc < 300) begin
         @(negedge clk);
         i_rst       = 1'b0;
         i_start     = (cyc == 0) || (cyc == 5);
         i_mode      = (cyc == 5) ? ~mode : mode;
         i_base_addr = (cyc == 5) ? 12'h555 : base;
         i_rd_gnt    = !(gnt_mode == 1 && cyc >= 10 && cyc <= 13);
         real_rsp = 0; i_rd_valid = 1'b0; i_rd_data = 8'h00;
         if (q_ready.size() > 0 && q_ready[0] <= cyc) begin
            real_rsp = 1; i_rd_valid = 1'b1;
            i_rd_data = data_const ? 8'd10 : 8'(q_idx[0] + 1);
            void'(q_ready.pop_front()); void'(q_idx.pop_front());
            nrsp++;
            if (first_valid < 0) first_valid = cyc;
            if (rst_beat > 0 && nrsp == rst_beat && rst_cyc < 0) begin
               i_rst = 1'b1; rst_cyc = cyc;
            end
         end else if (cyc == spur_cyc) begin
            i_rd_valid = 1'b1; i_rd_data = 8'h55;
         end
         #1;
         if ($isunknown({o_rd_req, o_rd_addr, o_clear, o_pix_data, o_coe_mode_addr, o_busy, o_done, o_err}))
            x_seen = 1;
         if (rst_cyc >= 0 && cyc == rst_cyc + 1)
            rst_zero = ({o_rd_req, o_rd_addr, o_clear, o_pix_data, o_coe_mode_addr, o_busy, o_done, o_err} == '0);
         if (rst_cyc >= 0 && cyc > rst_cyc && o_err) err_after_rst = 1;
         om = nreq - (nrsp - int'(real_rsp));
         if (o_rd_req && om >= 4) req_at_full = 1;
         if (om > max_outst) max_outst = om;
         if (o_rd_req && i_rd_gnt) begin
            grant_addr.push_back(o_rd_addr);
            q_ready.push_back(cyc + lat);
            q_idx.push_back((11 + nreq) % 16);
            nreq++;
            if (first_valid < 0) grants_before_valid++;
         end
         if (real_rsp && (rst_cyc < 0 || cyc == rst_cyc)) begin
            beat_coe.push_back(o_coe_mode_addr);
            beat_pix.push_back(o_pix_data);
         end
         if (cyc == spur_cyc) spur_pix = o_pix_data;
         if (cyc == spur_cyc + 1) err_after_spur = o_err;
         if (cyc == 1) err_at_c1 = o_err;
         if (o_clear) begin clear_cnt++; clear_cyc = cyc; end
         if (o_busy) begin busy_cnt++; if (busy_first < 0) busy_first = cyc; busy_last = cyc; end
         if (o_done) begin done_cnt++; done_cyc = cyc; err_at_done = o_err; end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) stop = 1;
         if (rst_cyc >= 0 && cyc >= rst_cyc + 3 && q_ready.size() == 0) stop = 1;
         if (!stop) cyc++;
      end
      n_cmp++;
      if (!stop) begin
         n_bad++;
         $display("FAIL window_timeout: ran %0d cycles, required completion within 300", cyc);
      end
      @(negedge clk);
      i_start = 1'b0; i_rd_valid = 1'b0; i_rd_gnt = 1'b0; i_rd_data = 8'h00;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_base_addr = 12'h000;
      i_rd_gnt = 1'b0; i_rd_valid = 1'b0; i_rd_data = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({o_rd_req, o_rd_addr, o_clear, o_pix_data, o_coe_mode_addr, o_busy, o_done, o_err} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got req=%b addr=%h clr=%b pix=%h coe=%h busy=%b done=%b err=%b, required all 0",
                  o_rd_req, o_rd_addr, o_clear, o_pix_data, o_coe_mode_addr, o_busy, o_done, o_err);
      end
      @(negedge clk);
      i_rst = 1'b0;
   endtask

   task automatic test_conv();
      logic [11:0] ea;
      logic [3:0]  ix;
      run_window(1'b0, 12'h100, 1, 0, 0, -1, 0);
      n_cmp++;
      if (grant_addr.size() != 16 || beat_coe.size() != 16) begin
         n_bad++;
         $display("FAIL conv_counts: got %0d grants %0d beats, required 16/16", grant_addr.size(), beat_coe.size());
      end else begin
         for (int k = 0; k < 16; k++) begin
            ix = 4'((11 + k) % 16);
            ea = 12'h100 + {8'h00, ix};
            n_cmp++;
            if (grant_addr[k] !== ea || beat_coe[k] !== {1'b0, ix} || beat_pix[k] !== 8'({4'h0, ix} + 8'd1)) begin
               n_bad++;
               $display("FAIL conv_beat[%0d]: got addr=%h coe=%h pix=%h, required addr=%h coe=%h pix=%h",
                        k, grant_addr[k], beat_coe[k], beat_pix[k], ea, {1'b0, ix}, {4'h0, ix} + 8'd1);
            end
         end
      end
      n_cmp++;
      if (clear_cyc != 1 || clear_cnt != 1) begin
         n_bad++;
         $display("FAIL conv_clear: got cycle %0d count %0d, required cycle 1 count 1", clear_cyc, clear_cnt);
      end
      n_cmp++;
      if (done_cyc != 19 || done_cnt != 1) begin
         n_bad++;
         $display("FAIL conv_done: got cycle %0d count %0d, required cycle 19 count 1", done_cyc, done_cnt);
      end
      n_cmp++;
      if (err_at_done !== 1'b0) begin
         n_bad++;
         $display("FAIL conv_err: got %b, required 0", err_at_done);
      end
   endtask

   task automatic test_sobel();
      int bad_beats = 0;
      run_window(1'b1, 12'h200, 1, 0, 1, -1, 0);
      for (int k = 0; k < beat_coe.size(); k++)
         if (beat_coe[k] !== {1'b1, 4'((11 + k) % 16)} || beat_pix[k] !== 8'd10) bad_beats++;
      n_cmp++;
      if (beat_coe.size() != 16 || bad_beats != 0) begin
         n_bad++;
         $display("FAIL sobel_beats: got %0d beats with %0d wrong, required 16 beats mode=1 pix=10", beat_coe.size(), bad_beats);
      end
      n_cmp++;
      if (busy_first != 1 || busy_last != 19 || busy_cnt != 19) begin
         n_bad++;
         $display("FAIL sobel_busy: got first=%0d last=%0d count=%0d, required 1/19/19", busy_first, busy_last, busy_cnt);
      end
   endtask

   task automatic test_backpressure();
      run_window(1'b0, 12'h040, 6, 1, 0, -1, 0);
      n_cmp++;
      if (grants_before_valid != 4) begin
         n_bad++;
         $display("FAIL bp_first_grants: got %0d, required 4", grants_before_valid);
      end
      n_cmp++;
      if (req_at_full || max_outst != 4) begin
         n_bad++;
         $display("FAIL bp_outst: got req_at_full=%b max=%0d, required 0 and 4", req_at_full, max_outst);
      end
      n_cmp++;
      if (beat_coe.size() != 16 || done_cnt != 1 || err_at_done !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_done: got beats=%0d done=%0d err=%b, required 16/1/0", beat_coe.size(), done_cnt, err_at_done);
      end
      n_cmp++;
      if (beat_coe.size() == 16 && beat_coe[15] !== 5'h0A) begin
         n_bad++;
         $display("FAIL bp_last_index: got %h, required 0a", beat_coe[15]);
      end
   endtask

   task automatic test_addr_wrap();
      run_window(1'b0, 12'hFFF, 1, 0, 0, -1, 0);
      n_cmp++;
      if (grant_addr.size() != 16 || grant_addr[0] !== 12'h00A || grant_addr[5] !== 12'hFFF) begin
         n_bad++;
         $display("FAIL wrap_addr: got count=%0d first=%h sixth=%h, required 16 00a fff",
                  grant_addr.size(), grant_addr.size() > 0 ? grant_addr[0] : 12'h000,
                  grant_addr.size() > 5 ? grant_addr[5] : 12'h000);
      end
      n_cmp++;
      if (x_seen) begin
         n_bad++;
         $display("FAIL wrap_no_x: got X on an output, required none");
      end
   endtask

   task automatic test_spurious();
      run_window(1'b0, 12'h100, 1, 0, 0, 1, 0);
      n_cmp++;
      if (spur_pix !== 8'h00) begin
         n_bad++;
         $display("FAIL spur_pix: got %h, required 00", spur_pix);
      end
      n_cmp++;
      if (err_after_spur !== 1'b1 || err_at_done !== 1'b1) begin
         n_bad++;
         $display("FAIL spur_err: got next=%b at_done=%b, required 1/1", err_after_spur, err_at_done);
      end
      n_cmp++;
      if (done_cyc != 19) begin
         n_bad++;
         $display("FAIL spur_done: got %0d, required 19", done_cyc);
      end
      run_window(1'b0, 12'h100, 1, 0, 0, -1, 0);
      n_cmp++;
      if (err_at_c1 !== 1'b0 || err_at_done !== 1'b0) begin
         n_bad++;
         $display("FAIL spur_err_clear: got c1=%b done=%b, required 0/0", err_at_c1, err_at_done);
      end
   endtask

   task automatic test_mid_reset();
      run_window(1'b1, 12'h300, 1, 0, 0, -1, 8);
      n_cmp++;
      if (!rst_zero) begin
         n_bad++;
         $display("FAIL rst_outputs: got nonzero outputs after reset, required all 0");
      end
      n_cmp++;
      if (err_after_rst || done_cnt != 0) begin
         n_bad++;
         $display("FAIL rst_late_rsp: got err=%b done=%0d, required 0/0", err_after_rst, done_cnt);
      end
      run_window(1'b0, 12'h080, 1, 0, 0, -1, 0);
      n_cmp++;
      if (done_cyc != 19 || beat_coe.size() != 16 || clear_cnt != 1) begin
         n_bad++;
         $display("FAIL rst_restart: got done=%0d beats=%0d clears=%0d, required 19/16/1", done_cyc, beat_coe.size(), clear_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_conv();
      test_sobel();
      test_backpressure();
      test_addr_wrap();
      test_spurious();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
